// File: rtl/tx_intf_pkg.sv
// Shared definitions for the TX DAC channel path: FSM state encoding and
// packed-bus geometry helpers.
package tx_intf_pkg;

    localparam logic [1:0] S_DMA   = 2'd0;
    localparam logic [1:0] S_ACC   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    function automatic int dac_pack_width(input int num_ant, input int iq_w);
        return num_ant * 2 * iq_w;
    endfunction

    function automatic int slot_lsb(input int slot, input int iq_w);
        return slot * 2 * iq_w;
    endfunction

endpackage

// File: rtl/tx_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata shows the head with no read latency.
module tx_sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level_q;
    logic                  pop_ok;
    logic                  push_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == (DEPTH_LOG2+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A pop frees the head slot in the same cycle, so a push at full is still taken.
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];
    assign level   = level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tx_dac_chan_mux.sv
// Selects DMA passthrough or a buffered accelerator stream for the DAC,
// replicating each accelerator sample onto the masked antenna slots.
module tx_dac_chan_mux
    import tx_intf_pkg::*;
#(
    parameter int IQ_DATA_WIDTH   = 16,
    parameter int NUM_ANT         = 2,
    parameter int FIFO_DEPTH_LOG2 = 5,
    localparam int DAC_PACK_DATA_WIDTH = dac_pack_width(NUM_ANT, IQ_DATA_WIDTH)
) (
    input  logic                           acc_clk,
    input  logic                           acc_rstn,
    output logic [DAC_PACK_DATA_WIDTH-1:0] dac_data,
    output logic                           dac_valid,
    input  logic                           dac_ready,
    input  logic [DAC_PACK_DATA_WIDTH-1:0] dma_data,
    input  logic                           dma_valid,
    output logic                           dma_ready,
    input  logic                           src_sel,
    input  logic [NUM_ANT-1:0]             ant_mask,
    input  logic [2*IQ_DATA_WIDTH-1:0]     data_from_acc,
    input  logic                           data_valid_from_acc,
    output logic                           fulln_to_acc,
    output logic [FIFO_DEPTH_LOG2:0]       fifo_level,
    output logic [15:0]                    underflow_cnt,
    output logic                           overflow_flag
);

    localparam int SAMPLE_W = 2 * IQ_DATA_WIDTH;

    logic [1:0]                     state;
    logic [NUM_ANT-1:0]             mask_q;
    logic                           armed;
    logic                           in_dma;
    logic                           fifo_push;
    logic                           fifo_pop;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [SAMPLE_W-1:0]            fifo_head;
    logic [DAC_PACK_DATA_WIDTH-1:0] acc_data;
    logic                           ovf_set;
    logic                           underflow_inc;

    assign in_dma        = (state == S_DMA);
    assign fifo_pop      = !in_dma && !fifo_empty && dac_ready;
    assign fifo_push     = data_valid_from_acc && !in_dma;
    assign ovf_set       = fifo_push && fifo_full && !fifo_pop;
    assign underflow_inc = (state == S_ACC) && armed && dac_ready && fifo_empty
                           && (underflow_cnt != 16'hFFFF);

    assign dac_valid     = in_dma ? dma_valid : !fifo_empty;
    assign dma_ready     = in_dma ? dac_ready : 1'b0;
    assign dac_data      = in_dma ? dma_data  : acc_data;
    assign fulln_to_acc  = !fifo_full;

    for (genvar k = 0; k < NUM_ANT; k++) begin : g_slot
        assign acc_data[slot_lsb(k, IQ_DATA_WIDTH) +: SAMPLE_W] =
            mask_q[k] ? fifo_head : '0;
    end

    tx_sync_fifo #(
        .WIDTH      (SAMPLE_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (acc_clk),
        .rst_n (acc_rstn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (data_from_acc),
        .rdata (fifo_head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge acc_clk or negedge acc_rstn) begin
        if (!acc_rstn) begin
            state         <= S_DMA;
            mask_q        <= '0;
            armed         <= 1'b0;
            underflow_cnt <= '0;
            overflow_flag <= 1'b0;
        end else begin
            if (ovf_set)       overflow_flag <= 1'b1;
            if (underflow_inc) underflow_cnt <= underflow_cnt + 16'd1;
            // Entry into S_ACC clears the sticky overflow; that clear wins over a same-cycle set.
            case (state)
                S_DMA: begin
                    if (src_sel && (!dma_valid || dac_ready)) begin
                        state         <= S_ACC;
                        mask_q        <= ant_mask;
                        armed         <= 1'b0;
                        overflow_flag <= 1'b0;
                    end
                end
                S_ACC: begin
                    if (fifo_pop) armed <= 1'b1;
                    if (!src_sel) begin
                        state <= S_DRAIN;
                        armed <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (src_sel) begin
                        state         <= S_ACC;
                        overflow_flag <= 1'b0;
                    end else if (fifo_empty && !fifo_pop) begin
                        state <= S_DMA;
                    end
                end
                default: state <= S_DMA;
            endcase
        end
    end

endmodule

// File: doc/tx_dac_chan_mux.md
TX_DAC_CHAN_MUX -- requirements
Module: tx_dac_chan_mux

Interface
REQ-001 SHALL have parameter IQ_DATA_WIDTH, default 16, the width of each I and Q component.
REQ-002 SHALL have parameter NUM_ANT, default 2, the number of DAC antenna slots (1..8).
REQ-003 SHALL have parameter FIFO_DEPTH_LOG2, default 5, giving a FIFO depth of 2**FIFO_DEPTH_LOG2 samples.
REQ-004 SHALL have localparam DAC_PACK_DATA_WIDTH = NUM_ANT*2*IQ_DATA_WIDTH; slot k occupies bits [(k+1)*2*IQ_DATA_WIDTH-1 : k*2*IQ_DATA_WIDTH].
REQ-005 SHALL have ports, with one clock and an asynchronous active-low reset (clock and reset listed first):
- acc_clk  in  1  sole clock
- acc_rstn  in  1  asynchronous active-low reset
- dac_data  out  DAC_PACK_DATA_WIDTH  packed samples to the DAC unpacker
- dac_valid  out  1  dac_data valid
- dac_ready  in  1  DAC accepts the beat
- dma_data  in  DAC_PACK_DATA_WIDTH  DMA samples
- dma_valid  in  1  DMA beat valid
- dma_ready  out  1  DMA beat accepted
- src_sel  in  1  0 = DMA source, 1 = accelerator source
- ant_mask  in  NUM_ANT  slots that receive the accelerator sample
- data_from_acc  in  2*IQ_DATA_WIDTH  accelerator IQ sample
- data_valid_from_acc  in  1  write strobe
- fulln_to_acc  out  1  FIFO not full
- fifo_level  out  FIFO_DEPTH_LOG2+1  current occupancy
- underflow_cnt  out  16  starved-read counter
- overflow_flag  out  1  sticky write-while-full flag

Function
REQ-006 SHALL implement FSM states S_DMA, S_ACC and S_DRAIN; the reset state is S_DMA.
REQ-007 In S_DMA, the block SHALL pass through combinationally: dac_data=dma_data, dac_valid=dma_valid, dma_ready=dac_ready.
REQ-008 S_DMA SHALL go to S_ACC on the clock edge where src_sel=1 and no DMA beat is stalled (dma_valid=0 or dac_ready=1).
REQ-009 In S_ACC and S_DRAIN, dma_ready SHALL be 0.
REQ-010 In S_ACC and S_DRAIN, dac_valid SHALL equal !empty.
REQ-011 In S_ACC and S_DRAIN, each slot SHALL carry the FIFO head when its mask_q bit is set, and zero otherwise.
REQ-012 mask_q SHALL be captured from ant_mask on entry to S_ACC and held until the next entry; mask_q=0 gives all-zero data with normal popping.
REQ-013 S_ACC SHALL go to S_DRAIN when src_sel=0.
REQ-014 S_DRAIN SHALL go to S_DMA when the FIFO is empty and no pop occurs that cycle.
REQ-015 S_DRAIN SHALL return to S_ACC if src_sel=1, keeping the existing mask_q.
REQ-016 The FIFO SHALL be synchronous and first-word-fall-through, with zero-cycle read latency.
REQ-017 The FIFO SHALL pop when dac_valid && dac_ready outside S_DMA.
REQ-018 The FIFO SHALL write when data_valid_from_acc && state != S_DMA && !full.
REQ-019 A simultaneous push and pop SHALL leave fifo_level unchanged, including at full and at empty+push (pop is blocked when empty).
REQ-020 A write attempted while full SHALL be dropped and SHALL set overflow_flag; writes in S_DMA SHALL be silently ignored.
REQ-021 overflow_flag SHALL clear only on reset or on entry to S_ACC.
REQ-022 Pointers SHALL wrap modulo depth; full = level == depth; fulln_to_acc = !full, registered-derived with no combinational path from inputs.
REQ-023 underflow_cnt SHALL increment, saturating at 16'hFFFF, in each S_ACC cycle with dac_ready=1 and empty=1, once armed.
REQ-024 Arming SHALL occur at the first pop after entering S_ACC; the armed state SHALL clear on leaving S_ACC; underflow_cnt itself clears only on reset.

Reset
REQ-025 On reset assertion, the block SHALL asynchronously force: state=S_DMA, pointers=0, fifo_level=0, mask_q=0, underflow_cnt=0, overflow_flag=0, armed=0.
REQ-026 During reset, outputs SHALL follow from the reset values: dac_valid=dma_valid (passthrough), fulln_to_acc=1.
REQ-027 Reset mid-transfer SHALL discard FIFO contents with no further dac_valid from the FIFO.
REQ-028 Reset deassertion SHALL be synchronised by the instantiating top; this block assumes nothing further.

Structure
REQ-029 The FSM state encoding and the DAC_PACK_DATA_WIDTH/slot-offset helper SHALL reside in shared package tx_intf_pkg.
REQ-030 The FIFO SHALL be a sub-module tx_sync_fifo (parameters WIDTH and DEPTH_LOG2, ports for level, full and empty); everything else SHALL be in tx_dac_chan_mux.

Verification
REQ-031 With src_sel=0 and dma_data=64'h1111_2222_3333_4444, valid, dac_ready=1: dac_data equal to it the same cycle, dma_ready=1.
REQ-032 With NUM_ANT=2, ant_mask=2'b10 and 3 samples 32'hA0000001..3 pushed: dac_data={sample,32'd0} for 3 beats, in order.
REQ-033 With ant_mask=2'b11 captured, then ant_mask changed to 2'b01 mid-stream: replication continues on both slots.
REQ-034 Push 33 samples with dac_ready=0: fulln_to_acc=0 after 32, overflow_flag=1, fifo_level=32; drain yields samples 1..32 only.
REQ-035 With src_sel 1->0 and 5 samples queued: state S_DRAIN, 5 beats emitted, then S_DMA and dma_ready follows dac_ready.
REQ-036 With FIFO emptied after the first pop and dac_ready=1 held 10 cycles in S_ACC: underflow_cnt=10; forcing it near 16'hFFFF shows saturation.
